pwm_dac: RTL and testbench



---
 rtl/pwm_dac_pkg.sv | 29 ++
 rtl/pwm_period_timer.sv | 34 +++
 rtl/pwm_dac.sv | 127 ++++++++++++
 tb/tb_pwm_dac.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared widths, phase limits and ramp FSM encodings for the PWM DAC output stage.
package pwm_dac_pkg;

  localparam int unsigned DUTY_W     = 7;
  localparam int unsigned DUTY_MAX   = 127;
  localparam int unsigned PHASE_LAST = DUTY_MAX - 1;
  localparam int unsigned PRESC_W    = 16;
  localparam int unsigned RAMP_W     = 8;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
  localparam logic [STATE_W-1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [STATE_W-1:0] ST_RAMP_DOWN = 2'd2;

  typedef logic [DUTY_W-1:0] duty_t;

  // One LSB toward tgt; holds when already there.
  function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
    duty_t res;
    res = cur;
    if (tgt > cur) begin
      res = cur + DUTY_W'(1);
    end else if (tgt < cur) begin
      res = cur - DUTY_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_period_timer.sv
// Prescaler and 127-slot phase counter; flags slot ticks and the PWM period boundary.
module pwm_period_timer
  import pwm_dac_pkg::*;
#(
  parameter int unsigned PRESCALE = 78
) (
  input  logic              clk,
  input  logic              reset_p,
  output logic [DUTY_W-1:0] phase,
  output logic              slot_tick_c,
  output logic              period_boundary_c
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [DUTY_W-1:0]  PHASE_END  = DUTY_W'(PHASE_LAST);

  logic [PRESC_W-1:0] presc;

  assign slot_tick_c       = (presc == PRESC_LAST);
  assign period_boundary_c = slot_tick_c && (phase == PHASE_END);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      presc <= '0;
      phase <= '0;
    end else if (slot_tick_c) begin
      presc <= '0;
      phase <= (phase == PHASE_END) ? '0 : phase + DUTY_W'(1);
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PWM DAC: soft-fading duty level applied only at period boundaries, compared against the phase.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int unsigned PRESCALE     = 78,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic [DUTY_W-1:0] level_in,
  input  logic              level_valid,
  input  logic              enable,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] level_now,
  output logic              busy,
  output logic              period_start
);

  localparam bit RAMP_OFF = (RAMP_PERIODS == 0);
  localparam logic [RAMP_W-1:0] RAMP_LAST =
    RAMP_OFF ? RAMP_W'(0) : RAMP_W'(RAMP_PERIODS - 1);

  logic [DUTY_W-1:0]  phase;
  logic               slot_tick_c;
  logic               period_boundary_c;
  logic               boundary_c;

  logic [DUTY_W-1:0]  target;
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [DUTY_W-1:0]  level_nxt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic [RAMP_W-1:0]  ramp_nxt;
  duty_t              stepped_c;

  pwm_period_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk               (clk),
    .reset_p           (reset_p),
    .phase             (phase),
    .slot_tick_c       (slot_tick_c),
    .period_boundary_c (period_boundary_c)
  );

  assign boundary_c = slot_tick_c && period_boundary_c;
  assign stepped_c  = step_toward(level_now, target);
  assign busy       = (level_now != target);

  // Last strobe wins; a boundary in the same cycle still sees the previous target.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      target <= '0;
    end else if (level_valid) begin
      target <= level_in;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state     <= ST_IDLE;
      level_now <= '0;
      ramp_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      level_now <= level_nxt;
      ramp_cnt  <= ramp_nxt;
    end
  end

  // Ramp decisions happen only at period boundaries so a period's duty never changes mid-way.
  always_comb begin
    state_nxt = state;
    level_nxt = level_now;
    ramp_nxt  = ramp_cnt;
    if (boundary_c) begin
      if (RAMP_OFF) begin
        state_nxt = ST_IDLE;
        level_nxt = target;
        ramp_nxt  = '0;
      end else begin
        case (state)
          ST_RAMP_UP, ST_RAMP_DOWN: begin
            if (target == level_now) begin
              state_nxt = ST_IDLE;
              ramp_nxt  = '0;
            end else begin
              // Direction follows the target; the step cadence is kept across a reversal.
              state_nxt = (target > level_now) ? ST_RAMP_UP : ST_RAMP_DOWN;
              if (ramp_cnt >= RAMP_LAST) begin
                level_nxt = stepped_c;
                ramp_nxt  = '0;
                if (stepped_c == target) begin
                  state_nxt = ST_IDLE;
                end
              end else begin
                ramp_nxt = ramp_cnt + RAMP_W'(1);
              end
            end
          end
          default: begin
            ramp_nxt = '0;
            if (target > level_now) begin
              state_nxt = ST_RAMP_UP;
            end else if (target < level_now) begin
              state_nxt = ST_RAMP_DOWN;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Phase tops out at 126, so level 127 is solid high and level 0 solid low.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
    end else begin
      pwm_out      <= enable && (phase < level_now);
      period_start <= boundary_c;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench: one instance with instant level changes, one with a 2-period soft ramp.
module tb_pwm_dac;
  import pwm_dac_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, vld_a, en_a, pwm_a, busy_a, ps_a;
  logic [DUTY_W-1:0] lvl_a, now_a;
  logic              rst_b, vld_b, en_b, pwm_b, busy_b, ps_b;
  logic [DUTY_W-1:0] lvl_b, now_b;

  int n_cmp = 0;
  int n_err = 0;

  pwm_dac #(.PRESCALE(1), .RAMP_PERIODS(0)) u_a (
    .clk (clk), .reset_p (rst_a), .level_in (lvl_a), .level_valid (vld_a),
    .enable (en_a), .pwm_out (pwm_a), .level_now (now_a), .busy (busy_a),
    .period_start (ps_a)
  );

  pwm_dac #(.PRESCALE(2), .RAMP_PERIODS(2)) u_b (
    .clk (clk), .reset_p (rst_b), .level_in (lvl_b), .level_valid (vld_b),
    .enable (en_b), .pwm_out (pwm_b), .level_now (now_b), .busy (busy_b),
    .period_start (ps_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps_a(output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm_a) hi++;
    end while (!ps_a && n < 2000);
    if (!ps_a) check("ps_a_timeout", 32'(ps_a), 1);
  endtask

  task automatic wait_ps_b(output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (pwm_b) hi++;
    end while (!ps_b && n < 2000);
    if (!ps_b) check("ps_b_timeout", 32'(ps_b), 1);
  endtask

  task automatic count_a(input int cycles, output int hi);
    hi = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (pwm_a) hi++;
    end
  endtask

  initial begin
    int n, hi;
    int exp_up[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
    int exp_rev[5] = '{3, 3, 2, 2, 1};

    rst_a = 1'b1; vld_a = 1'b0; en_a = 1'b1; lvl_a = '0;
    rst_b = 1'b1; vld_b = 1'b0; en_b = 1'b1; lvl_b = '0;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_a), 0);
    check("rst_level", 32'(now_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_ps", 32'(ps_a), 0);
    check("rst_state_b", 32'(u_b.state), 32'(ST_IDLE));
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Idle at level 0: period_start every 127 clk, output never high.
    wait_ps_a(n, hi);
    check("first_ps_spacing", n, 127);
    check("lvl0_idle_highs", hi, 0);
    wait_ps_a(n, hi);
    check("ps_spacing", n, 127);
    check("lvl0_idle_highs2", hi, 0);
    check("lvl0_level_now", 32'(now_a), 0);

    // Level 32 applied at the next boundary; high exactly on phases 0..31.
    lvl_a = 7'd32; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    check("busy_after_strobe", 32'(busy_a), 1);
    wait_ps_a(n, hi);
    check("lvl32_level_now", 32'(now_a), 32);
    check("lvl32_busy", 32'(busy_a), 0);
    hi = 0;
    for (int k = 1; k <= 127; k++) begin
      @(negedge clk);
      if (pwm_a) hi++;
      if (k == 1)  check("duty32_first_hi", 32'(pwm_a), 1);
      if (k == 32) check("duty32_last_hi", 32'(pwm_a), 1);
      if (k == 33) check("duty32_first_lo", 32'(pwm_a), 0);
    end
    check("duty32_highs", hi, 32);
    check("duty32_next_ps", 32'(ps_a), 1);

    // Level 127 solid high, then level 0 solid low, over three periods each.
    lvl_a = 7'd127; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    wait_ps_a(n, hi);
    count_a(381, hi);
    check("lvl127_lows", 381 - hi, 0);
    lvl_a = 7'd0; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    wait_ps_a(n, hi);
    count_a(381, hi);
    check("lvl0_highs", hi, 0);

    // Enable gating at level 64: low one clk after the drop, resumes mid-period.
    lvl_a = 7'd64; vld_a = 1'b1;
    @(negedge clk);
    vld_a = 1'b0;
    wait_ps_a(n, hi);
    repeat (5) @(negedge clk);
    check("en_pre_hi", 32'(pwm_a), 1);
    en_a = 1'b0;
    @(negedge clk);
    check("en_off_1clk", 32'(pwm_a), 0);
    count_a(49, hi);
    check("en_off_highs", hi, 0);
    check("en_off_level", 32'(now_a), 64);
    en_a = 1'b1;
    @(negedge clk);
    check("en_resume_hi", 32'(pwm_a), 1);
    wait_ps_a(n, hi);
    count_a(127, hi);
    check("duty64_highs", hi, 64);

    // Asynchronous reset while the output is high.
    repeat (10) @(negedge clk);
    check("rst_mid_pre_hi", 32'(pwm_a), 1);
    rst_a = 1'b1;
    #1;
    check("rst_mid_pwm", 32'(pwm_a), 0);
    check("rst_mid_level", 32'(now_a), 0);
    check("rst_mid_busy", 32'(busy_a), 0);
    check("rst_mid_ps", 32'(ps_a), 0);
    @(negedge clk);
    rst_a = 1'b0;
    wait_ps_a(n, hi);
    check("rst_release_ps", n, 127);

    // Soft ramp 0 -> 5, one step every two periods.
    wait_ps_b(n, hi);
    lvl_b = 7'd5; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    check("ramp_busy_start", 32'(busy_b), 1);
    for (int i = 0; i < 11; i++) begin
      wait_ps_b(n, hi);
      check($sformatf("ramp_up_lvl%0d", i), 32'(now_b), 32'(exp_up[i]));
      check($sformatf("ramp_up_busy%0d", i), 32'(busy_b), (i < 10) ? 32'd1 : 32'd0);
      if (i == 1) check("ramp_up_state", 32'(u_b.state), 32'(ST_RAMP_UP));
    end
    check("ramp_up_idle", 32'(u_b.state), 32'(ST_IDLE));

    // Back down to 3.
    lvl_b = 7'd3; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    repeat (5) wait_ps_b(n, hi);
    check("down3_level", 32'(now_b), 3);
    check("down3_idle", 32'(u_b.state), 32'(ST_IDLE));

    // Rising toward 10, reversed to 1 by a strobe landing on a boundary cycle.
    lvl_b = 7'd10; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    repeat (3) wait_ps_b(n, hi);
    check("rev_pre_level", 32'(now_b), 4);
    repeat (253) @(negedge clk);
    lvl_b = 7'd1; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    check("rev_strobe_on_boundary", 32'(ps_b), 1);
    check("rev_old_target_level", 32'(now_b), 4);
    check("rev_old_target_state", 32'(u_b.state), 32'(ST_RAMP_UP));
    for (int i = 0; i < 5; i++) begin
      wait_ps_b(n, hi);
      check($sformatf("rev_lvl%0d", i), 32'(now_b), 32'(exp_rev[i]));
      if (i == 0) check("rev_state_down", 32'(u_b.state), 32'(ST_RAMP_DOWN));
    end
    check("rev_idle", 32'(u_b.state), 32'(ST_IDLE));
    check("rev_busy", 32'(busy_b), 0);

    // Enable low across a boundary: output stays low while the ramp still steps.
    lvl_b = 7'd5; vld_b = 1'b1;
    @(negedge clk);
    vld_b = 1'b0;
    repeat (2) wait_ps_b(n, hi);
    repeat (230) @(negedge clk);
    en_b = 1'b0;
    hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (pwm_b) hi++;
    end
    check("b_en_off_highs", hi, 0);
    check("b_en_off_level", 32'(now_b), 2);
    en_b = 1'b1;
    wait_ps_b(n, hi);
    wait_ps_b(n, hi);
    check("b_duty2_highs", hi, 4);
    check("b_step3_level", 32'(now_b), 3);

    // Reset mid-ramp.
    repeat (2) @(negedge clk);
    check("b_rst_pre_hi", 32'(pwm_b), 1);
    rst_b = 1'b1;
    #1;
    check("b_rst_pwm", 32'(pwm_b), 0);
    check("b_rst_level", 32'(now_b), 0);
    check("b_rst_busy", 32'(busy_b), 0);
    check("b_rst_state", 32'(u_b.state), 32'(ST_IDLE));
    @(negedge clk);
    rst_b = 1'b0;
    wait_ps_b(n, hi);
    check("b_rst_release_ps", n, 254);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
